// File: rtl/deserializer_if.sv
// Serial-in / parallel-out handshake bundle for the deserializer.
// The master is the bit source and word sink; the slave is the deserializer.
interface deserializer_if #(
   parameter int C_WIDTH = 2
);
   logic               serial_i;
   logic               serial_valid_i;
   logic               align_i;
   logic               ready_i;
   logic               overrun_clr_i;
   logic [C_WIDTH-1:0] data_o;
   logic               valid_o;
   logic               overrun_o;

   modport master (
      output serial_i, serial_valid_i, align_i, ready_i, overrun_clr_i,
      input  data_o, valid_o, overrun_o
   );

   modport slave (
      input  serial_i, serial_valid_i, align_i, ready_i, overrun_clr_i,
      output data_o, valid_o, overrun_o
   );
endinterface

// File: rtl/deserializer.sv
// LSB-first serial-to-parallel converter with a single-entry output register,
// re-alignment control and a sticky overrun flag for dropped words.
module deserializer #(
   parameter int C_WIDTH = 2
) (
   input logic            clk_i,
   input logic            rst_i,
   deserializer_if.slave  bus
);
   localparam int                CNT_W    = (C_WIDTH > 2) ? $clog2(C_WIDTH) : 1;
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(C_WIDTH - 1);

   logic [CNT_W-1:0]   r_cnt;
   logic [C_WIDTH-1:0] r_asm;
   logic [C_WIDTH-1:0] r_data;
   logic               r_valid;
   logic               r_ovr;

   logic [CNT_W-1:0]   w_cnt_base;
   logic [C_WIDTH-1:0] w_asm_base;
   logic [C_WIDTH-1:0] w_word;
   logic               w_complete;
   logic               w_consume;
   logic               w_load;
   logic               w_drop;

   // Align discards the partial word so the bit arriving with it becomes bit 0.
   always_comb begin
      w_cnt_base         = bus.align_i ? '0 : r_cnt;
      w_asm_base         = bus.align_i ? '0 : r_asm;
      w_word             = w_asm_base;
      w_word[w_cnt_base] = bus.serial_i;
      w_complete         = bus.serial_valid_i && (w_cnt_base == LAST_IDX);
      w_consume          = r_valid && bus.ready_i;
      w_load             = w_complete && (!r_valid || bus.ready_i);
      w_drop             = w_complete && r_valid && !bus.ready_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt   <= '0;
         r_asm   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         if (bus.serial_valid_i) begin
            r_cnt <= w_complete ? '0 : w_cnt_base + CNT_W'(1);
            r_asm <= w_complete ? '0 : w_word;
         end else begin
            r_cnt <= w_cnt_base;
            r_asm <= w_asm_base;
         end

         if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
         end else if (w_consume) begin
            r_valid <= 1'b0;
         end

         // A fresh drop outranks a clear request in the same cycle.
         if (w_drop) begin
            r_ovr <= 1'b1;
         end else if (bus.overrun_clr_i) begin
            r_ovr <= 1'b0;
         end
      end
   end

   assign bus.data_o    = r_data;
   assign bus.valid_o   = r_valid;
   assign bus.overrun_o = r_ovr;
endmodule

// File: tb/tb_deserializer.sv
// Drives one shared bit stream into 2-, 4- and 8-bit deserializers and checks
// every cycle against a queue-based reference model of word framing.
module tb_deserializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic t_ser = 1'b0, t_sv = 1'b0, t_align = 1'b0, t_ready = 1'b0, t_clr = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   deserializer_if #(.C_WIDTH(2)) if2 ();
   deserializer_if #(.C_WIDTH(4)) if4 ();
   deserializer_if #(.C_WIDTH(8)) if8 ();

   assign if2.serial_i = t_ser;   assign if4.serial_i = t_ser;   assign if8.serial_i = t_ser;
   assign if2.serial_valid_i = t_sv; assign if4.serial_valid_i = t_sv; assign if8.serial_valid_i = t_sv;
   assign if2.align_i = t_align;  assign if4.align_i = t_align;  assign if8.align_i = t_align;
   assign if2.ready_i = t_ready;  assign if4.ready_i = t_ready;  assign if8.ready_i = t_ready;
   assign if2.overrun_clr_i = t_clr; assign if4.overrun_clr_i = t_clr; assign if8.overrun_clr_i = t_clr;

   deserializer #(.C_WIDTH(2)) u_w2 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));
   deserializer #(.C_WIDTH(4)) u_w4 (.clk_i(clk), .rst_i(rst), .bus(if4.slave));
   deserializer #(.C_WIDTH(8)) u_w8 (.clk_i(clk), .rst_i(rst), .bus(if8.slave));

   // Reference model: pending bits kept in a queue, word formed when full.
   int          wid [3] = '{2, 4, 8};
   bit          m_part [3][$];
   logic [63:0] m_data [3];
   logic        m_valid [3];
   logic        m_ovr [3];

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         logic        done;
         logic [63:0] word;
         done = 1'b0;
         word = '0;
         if (rst) begin
            m_part[k].delete();
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
            m_ovr[k]   = 1'b0;
         end else begin
            if (t_align) m_part[k].delete();
            if (t_sv) begin
               m_part[k].push_back(t_ser);
               if (m_part[k].size() == wid[k]) begin
                  for (int i = 0; i < wid[k]; i++) word = word + (64'(m_part[k][i]) << i);
                  m_part[k].delete();
                  done = 1'b1;
               end
            end
            if (done && m_valid[k] && !t_ready) begin
               m_ovr[k] = 1'b1;
            end else begin
               if (t_clr) m_ovr[k] = 1'b0;
               if (done) begin
                  m_data[k]  = word;
                  m_valid[k] = 1'b1;
               end else if (m_valid[k] && t_ready) begin
                  m_valid[k] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic al, input logic sv, input logic s,
                       input logic rdy, input logic clr);
      logic [63:0] o_d [3];
      logic        o_v [3];
      logic        o_o [3];
      rst = r; t_align = al; t_sv = sv; t_ser = s; t_ready = rdy; t_clr = clr;
      @(posedge clk);
      model_edge();
      #1;
      o_d[0] = 64'(if2.data_o); o_v[0] = if2.valid_o; o_o[0] = if2.overrun_o;
      o_d[1] = 64'(if4.data_o); o_v[1] = if4.valid_o; o_o[1] = if4.overrun_o;
      o_d[2] = 64'(if8.data_o); o_v[2] = if8.valid_o; o_o[2] = if8.overrun_o;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("w%0d_valid", wid[k]), 64'(o_v[k]), 64'(m_valid[k]));
         check($sformatf("w%0d_data", wid[k]), o_d[k], m_data[k]);
         check($sformatf("w%0d_overrun", wid[k]), 64'(o_o[k]), 64'(m_ovr[k]));
      end
   endtask

   initial begin
      logic [7:0] a5;
      logic [3:0] pat;
      a5  = 8'hA5;
      pat = 4'b1000;

      // Reset state
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1, 1);

      // Two-bit word 1,0 -> 2'b01, valid for one cycle
      step(0, 0, 1, 1, 1, 0);
      step(0, 0, 1, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);

      // 0xA5 LSB first with serial_valid toggling
      step(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, a5[i], 1, 0);
         step(0, 0, 0, ~a5[i], 1, 0);
      end

      // Overrun: words 2'b10 then 2'b11 with ready low, clear, then set-wins
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);

      // Partial word 1,1,1 discarded by align carrying bit 0 of 4'b1000
      step(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(0, (i == 0), 1, pat[i], 1, 0);
      step(0, 0, 0, 0, 1, 0);

      // Back-to-back words with ready held high
      for (int i = 0; i < 24; i++) step(0, 0, 1, 1'($urandom), 1, 0);

      // Reset mid-word, then word 1,1
      step(0, 1, 1, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      step(0, 0, 1, 1, 1, 0);
      step(0, 0, 1, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom),
              ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 7) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 C_WIDTH, default 2, SHALL be the parallel word width in bits; legal range 2..64.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 serial_i  input  1  SHALL carry the serial data bit.
REQ-005 serial_valid_i  input  1  SHALL qualify serial_i; a bit is accepted only in a cycle where it is high.
REQ-006 align_i  input  1  SHALL restart word framing: discard any partial word and treat the next accepted bit as bit 0.
REQ-007 data_o  output  C_WIDTH  SHALL present the assembled parallel word.
REQ-008 valid_o  output  1  SHALL indicate data_o holds an unconsumed word.
REQ-009 ready_i  input  1  SHALL indicate the sink consumes data_o in a cycle where valid_o is also high.
REQ-010 overrun_o  output  1  SHALL be a sticky flag set when a completed word is dropped.
REQ-011 overrun_clr_i  input  1  SHALL clear overrun_o.

Function
REQ-012 Bit order SHALL be LSB first: the first accepted bit after reset or align lands in data bit 0, the k-th in bit k-1.
REQ-013 A bit counter of width max(1,$clog2(C_WIDTH)) SHALL count accepted bits 0..C_WIDTH-1 and wrap to 0 after C_WIDTH-1.
REQ-014 Accepted bits SHALL be written into an internal shift/assembly register; no change when serial_valid_i is low.
REQ-015 When the bit accepted has counter value C_WIDTH-1, the word SHALL be complete and SHALL be loaded into the output register on the same edge.
REQ-016 Latency SHALL be 1 cycle: valid_o high and data_o updated in the cycle after the last bit is accepted.
REQ-017 The output register SHALL be loadable when valid_o is low, or when valid_o and ready_i are both high in the completing cycle (simultaneous consume and load, no bubble).
REQ-018 If a word completes while valid_o is high and ready_i is low, the new word SHALL be dropped, data_o SHALL keep the old word, and overrun_o SHALL be set on that edge.
REQ-019 valid_o SHALL fall on the edge after a cycle with valid_o and ready_i high, unless a new word loads on that same edge.
REQ-020 data_o SHALL stay stable while valid_o is high and ready_i is low.
REQ-021 align_i high SHALL reset the bit counter and clear the partial word; if serial_valid_i is also high, that cycle's bit SHALL be accepted as bit 0.
REQ-022 align_i SHALL NOT affect valid_o, data_o or overrun_o.
REQ-023 overrun_clr_i and a new overrun event in the same cycle SHALL leave overrun_o set (set wins).
REQ-024 ready_i while valid_o is low SHALL have no effect.

Reset
REQ-025 On rst_i high at a rising edge: bit counter 0, assembly register 0, data_o 0, valid_o 0, overrun_o 0.
REQ-026 Reset mid-word SHALL discard all partial bits; the first accepted bit after reset release is bit 0.
REQ-027 rst_i SHALL take priority over align_i, serial_valid_i, ready_i and overrun_clr_i.

Verification
REQ-028 C_WIDTH=2, ready_i=1, bits 1,0 with serial_valid_i high on consecutive cycles -> next cycle valid_o=1, data_o=2'b01; valid_o 1 for one cycle.
REQ-029 C_WIDTH=8, ready_i=1, stream of 0xA5 LSB first with serial_valid_i toggling 1,0,1,0... -> valid_o one cycle after 8th accepted bit, data_o=8'hA5.
REQ-030 C_WIDTH=2, ready_i=0, send words 2'b10 then 2'b11 -> data_o stays 2'b10, valid_o=1, overrun_o=1 one cycle after 4th bit; pulse overrun_clr_i -> overrun_o=0.
REQ-031 C_WIDTH=4, send 3 bits 1,1,1, then align_i with serial_valid_i=1, bits 0,0,0,1 -> data_o=4'b1000, no word from the partial bits.
REQ-032 C_WIDTH=2, continuous words with ready_i=1 every cycle -> back-to-back valid_o each word, no overrun_o.
REQ-033 rst_i asserted after 1 of 2 bits, then bits 1,1 -> after reset all outputs 0; following word data_o=2'b11.
